// File: rtl/cacc_pkg.sv
// Shared types and constants for the CACC partial-sum sequencer.
package cacc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int unsigned CALC_LAT = 2;
   localparam int unsigned PSUM_W   = 34;
   localparam int unsigned MAC_W    = 22;

endpackage

// File: rtl/cacc_psum_buf.sv
// Partial-sum register file: one combinational read port, one write port,
// with same-cycle write-to-read forwarding.
module cacc_psum_buf
   import cacc_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [PSUM_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [PSUM_W-1:0] rdata_c
);

   logic [PSUM_W-1:0] mem_q [DEPTH];

   // Contents are deliberately not reset; entries are always written before use.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata_c = (we && (waddr == raddr)) ? wdata : mem_q[raddr];

endmodule

// File: rtl/cacc_psum_sequencer.sv
// Sequences the MAC stream into the CACC calc stage, tracking stripe/group
// position and holding partial sums between channel groups.
module cacc_psum_sequencer
   import cacc_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rstn,
   input  logic [AW:0]       cfg_stripe_len,
   input  logic [7:0]        cfg_group_num,
   input  logic              op_en,
   input  logic              mac_pvld,
   output logic              mac_prdy,
   input  logic [MAC_W-1:0]  mac_data,
   output logic [MAC_W-1:0]  calc_in_data,
   output logic [PSUM_W-1:0] calc_in_op,
   output logic              calc_in_op_valid,
   output logic              calc_in_sel,
   output logic              calc_in_valid,
   input  logic [PSUM_W-1:0] calc_partial_data,
   input  logic              calc_partial_valid,
   output logic              busy,
   output logic              layer_done,
   output logic              err_wb
);

   localparam int unsigned LW = AW + 1;

   state_e           state_q, state_d;
   logic [LW-1:0]    stripe_q, stripe_d;
   logic [7:0]       gnum_q, gnum_d;
   logic [AW-1:0]    atom_q, atom_d;
   logic [7:0]       group_q, group_d;
   logic [AW-1:0]    wb_addr_q, wb_addr_d;
   logic [DEPTH-1:0] pend_q, pend_d;
   logic [1:0]       drain_q, drain_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             hazard_c;
   logic             accept_c;
   logic             last_atom_c;
   logic             last_wb_c;
   logic [PSUM_W-1:0] buf_rdata_c;

   cacc_psum_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk     (nvdla_core_clk),
      .we      (calc_partial_valid),
      .waddr   (wb_addr_q),
      .wdata   (calc_partial_data),
      .raddr   (atom_q),
      .rdata_c (buf_rdata_c)
   );

   // Stall only when the entry is still owed a write-back that is not landing now.
   assign hazard_c    = pend_q[atom_q] & ~(calc_partial_valid & (wb_addr_q == atom_q));
   assign mac_prdy    = (state_q == RUN) & ~hazard_c;
   assign accept_c    = mac_pvld & mac_prdy;
   assign last_atom_c = (atom_q == AW'(stripe_q - LW'(1)));
   assign last_wb_c   = (wb_addr_q == AW'(stripe_q - LW'(1)));

   assign calc_in_valid    = accept_c;
   assign calc_in_data     = accept_c ? mac_data : '0;
   assign calc_in_op_valid = accept_c & (group_q != 8'd0);
   assign calc_in_sel      = accept_c & (group_q == gnum_q);
   assign calc_in_op       = calc_in_op_valid ? buf_rdata_c : '0;

   assign busy       = busy_q;
   assign layer_done = done_q;
   assign err_wb     = err_q;

   always_comb begin
      state_d   = state_q;
      stripe_d  = stripe_q;
      gnum_d    = gnum_q;
      atom_d    = atom_q;
      group_d   = group_q;
      wb_addr_d = wb_addr_q;
      pend_d    = pend_q;
      drain_d   = drain_q;
      done_d    = 1'b0;
      err_d     = err_q;

      if (calc_partial_valid) begin
         pend_d[wb_addr_q] = 1'b0;
         if (!pend_q[wb_addr_q]) begin
            err_d = 1'b1;
         end
         wb_addr_d = last_wb_c ? '0 : wb_addr_q + AW'(1);
      end
      // Set after clear so a same-cycle set wins.
      if (accept_c && !calc_in_sel) begin
         pend_d[atom_q] = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (op_en) begin
               state_d   = RUN;
               stripe_d  = cfg_stripe_len;
               gnum_d    = cfg_group_num;
               atom_d    = '0;
               group_d   = '0;
               wb_addr_d = '0;
               drain_d   = '0;
            end
         end
         RUN: begin
            if (accept_c) begin
               if (last_atom_c) begin
                  atom_d = '0;
                  if (group_q == gnum_q) begin
                     state_d = DRAIN;
                     drain_d = '0;
                  end else begin
                     group_d = group_q + 8'd1;
                  end
               end else begin
                  atom_d = atom_q + AW'(1);
               end
            end
         end
         DRAIN: begin
            if (drain_q == 2'(CALC_LAT - 1)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         state_q   <= IDLE;
         stripe_q  <= LW'(1);
         gnum_q    <= '0;
         atom_q    <= '0;
         group_q   <= '0;
         wb_addr_q <= '0;
         pend_q    <= '0;
         drain_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         stripe_q  <= stripe_d;
         gnum_q    <= gnum_d;
         atom_q    <= atom_d;
         group_q   <= group_d;
         wb_addr_q <= wb_addr_d;
         pend_q    <= pend_d;
         drain_q   <= drain_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_cacc_psum_sequencer.sv
// Bench for cacc_psum_sequencer: attached 2-cycle calc model, table-driven
// layers, hand-written corner sequences and randomized layers.
module tb_cacc_psum_sequencer;

   localparam int unsigned AW = 5;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [AW:0] cfg_stripe_len = '0;
   logic [7:0]  cfg_group_num = '0;
   logic        op_en = 1'b0;
   logic        mac_pvld = 1'b0;
   logic        mac_prdy;
   logic [21:0] mac_data = '0;
   logic [21:0] calc_in_data;
   logic [33:0] calc_in_op;
   logic        calc_in_op_valid;
   logic        calc_in_sel;
   logic        calc_in_valid;
   logic [33:0] calc_partial_data;
   logic        calc_partial_valid;
   logic        busy;
   logic        layer_done;
   logic        err_wb;

   always #5 clk = ~clk;

   cacc_psum_sequencer #(.DEPTH(32), .AW(AW)) dut (
      .nvdla_core_clk     (clk),
      .nvdla_core_rstn    (rstn),
      .cfg_stripe_len     (cfg_stripe_len),
      .cfg_group_num      (cfg_group_num),
      .op_en              (op_en),
      .mac_pvld           (mac_pvld),
      .mac_prdy           (mac_prdy),
      .mac_data           (mac_data),
      .calc_in_data       (calc_in_data),
      .calc_in_op         (calc_in_op),
      .calc_in_op_valid   (calc_in_op_valid),
      .calc_in_sel        (calc_in_sel),
      .calc_in_valid      (calc_in_valid),
      .calc_partial_data  (calc_partial_data),
      .calc_partial_valid (calc_partial_valid),
      .busy               (busy),
      .layer_done         (layer_done),
      .err_wb             (err_wb)
   );

   // Calc stage model: non-final issues return op + data two cycles later.
   logic        cap_v = 1'b0, s1_v = 1'b0, s2_v = 1'b0, inj_v = 1'b0;
   logic [33:0] cap_d = '0, s1_d = '0, s2_d = '0;

   always @(negedge clk) begin
      cap_v <= calc_in_valid & ~calc_in_sel;
      cap_d <= {{12{calc_in_data[21]}}, calc_in_data} + calc_in_op;
   end

   always @(posedge clk) begin
      if (!rstn) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         s1_v <= cap_v;
         s1_d <= cap_d;
         s2_v <= s1_v;
         s2_d <= s1_d;
      end
   end

   assign calc_partial_valid = s2_v | inj_v;
   assign calc_partial_data  = s2_d;

   int total = 0;
   int bad   = 0;
   int dat [256];

   typedef struct {
      int s;
      int gn;
      int mode;
      int exp_last;
      int exp_stalls;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < 256; i++) begin
         case (mode)
            0:       dat[i] = (i % 4) + 1;
            1:       dat[i] = 5;
            default: dat[i] = int'($urandom_range(0, 2097151)) - 1048576;
         endcase
      end
   endtask

   // Expected operand of issue k is the sum of the earlier groups' data at the same atom.
   task automatic run_layer(input int s, input int gn, input bit gaps, input bit poke,
                            input int exp_last, input int exp_stalls);
      int     n_iss;
      int     acc, cyc, last, done, stalls, a, g;
      bit     busy_at_done;
      longint exp_op;
      n_iss = s * (gn + 1);
      acc = 0; last = -1; done = -1; stalls = 0; busy_at_done = 1'b1;
      step();
      cfg_stripe_len = (AW + 1)'(s);
      cfg_group_num  = 8'(gn);
      op_en    = 1'b1;
      mac_pvld = 1'b0;
      @(negedge clk);
      chk("prdy_at_op_en", 64'(mac_prdy), 64'd0);
      step();
      op_en = 1'b0;
      cyc = 1;
      while (done < 0 && cyc < 3000) begin
         cfg_stripe_len = (AW + 1)'($urandom_range(1, 32));
         cfg_group_num  = 8'($urandom);
         op_en    = poke && (cyc == 3);
         mac_pvld = (acc < n_iss) && (!gaps || $urandom_range(0, 2) != 0);
         mac_data = 22'((acc < n_iss) ? dat[acc] : 0);
         @(negedge clk);
         if (cyc == 1) chk("prdy_first", 64'(mac_prdy), 64'd1);
         if (mac_pvld && !mac_prdy) stalls++;
         if (mac_pvld && mac_prdy) begin
            a = acc % s;
            g = acc / s;
            exp_op = 0;
            for (int h = 0; h < g; h++) exp_op += longint'(dat[h * s + a]);
            chk("in_valid", 64'(calc_in_valid), 64'd1);
            chk("in_data", {{42{calc_in_data[21]}}, calc_in_data}, longint'(dat[acc]));
            chk("in_op_valid", 64'(calc_in_op_valid), 64'(g != 0));
            chk("in_sel", 64'(calc_in_sel), 64'(g == gn));
            chk("in_op", {{30{calc_in_op[33]}}, calc_in_op}, exp_op);
            last = cyc;
            acc++;
         end
         if (layer_done) begin
            done = cyc;
            busy_at_done = busy;
         end
         step();
         cyc++;
      end
      op_en = 1'b0;
      mac_pvld = 1'b0;
      chk("done_seen", 64'(done >= 0), 64'd1);
      chk("accepts", 64'(acc), 64'(n_iss));
      if (!gaps) begin
         chk("last_accept", 64'(last), 64'(exp_last));
         chk("stalls", 64'(stalls), 64'(exp_stalls));
      end
      chk("done_delay", 64'(done - last), 64'd3);
      chk("busy_at_done", 64'(busy_at_done), 64'd0);
      chk("err_wb_clean", 64'(err_wb), 64'd0);
      @(negedge clk);
      chk("done_pulse", 64'(layer_done), 64'd0);
   endtask

   initial begin
      int acc, guard;
      tbl[0] = '{s: 4,  gn: 2, mode: 0, exp_last: 12, exp_stalls: 0};
      tbl[1] = '{s: 1,  gn: 3, mode: 1, exp_last: 7,  exp_stalls: 3};
      tbl[2] = '{s: 2,  gn: 1, mode: 2, exp_last: 4,  exp_stalls: 0};
      tbl[3] = '{s: 3,  gn: 0, mode: 2, exp_last: 3,  exp_stalls: 0};
      tbl[4] = '{s: 32, gn: 1, mode: 2, exp_last: 64, exp_stalls: 0};
      tbl[5] = '{s: 1,  gn: 0, mode: 2, exp_last: 1,  exp_stalls: 0};
      tbl[6] = '{s: 2,  gn: 3, mode: 2, exp_last: 8,  exp_stalls: 0};

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_prdy", 64'(mac_prdy), 64'd0);
      chk("rst_valid", 64'(calc_in_valid), 64'd0);
      chk("rst_op_valid", 64'(calc_in_op_valid), 64'd0);
      chk("rst_sel", 64'(calc_in_sel), 64'd0);
      chk("rst_data", 64'(calc_in_data), 64'd0);
      chk("rst_op", 64'(calc_in_op), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(layer_done), 64'd0);
      chk("rst_err", 64'(err_wb), 64'd0);
      step();
      rstn = 1'b1;

      // Stray write-back while idle sets a sticky error
      step();
      inj_v = 1'b1;
      @(negedge clk);
      chk("err_before", 64'(err_wb), 64'd0);
      step();
      inj_v = 1'b0;
      @(negedge clk);
      chk("err_rise", 64'(err_wb), 64'd1);
      repeat (3) step();
      @(negedge clk);
      chk("err_sticky", 64'(err_wb), 64'd1);
      step();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      @(negedge clk);
      chk("err_cleared", 64'(err_wb), 64'd0);

      foreach (tbl[i]) begin
         fill(tbl[i].mode);
         run_layer(tbl[i].s, tbl[i].gn, 1'b0, 1'b0, tbl[i].exp_last, tbl[i].exp_stalls);
      end

      // Abort a 4x3 layer after 5 accepts, then restart cleanly
      fill(0);
      step();
      cfg_stripe_len = (AW + 1)'(4);
      cfg_group_num  = 8'd2;
      op_en = 1'b1;
      step();
      op_en = 1'b0;
      acc = 0;
      guard = 0;
      while (acc < 5 && guard < 50) begin
         mac_pvld = 1'b1;
         mac_data = 22'(dat[acc]);
         @(negedge clk);
         if (mac_prdy) acc++;
         step();
         guard++;
      end
      chk("abort_accepts", 64'(acc), 64'd5);
      mac_pvld = 1'b0;
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_prdy", 64'(mac_prdy), 64'd0);
      chk("abort_valid", 64'(calc_in_valid), 64'd0);
      fill(2);
      run_layer(4, 2, 1'b0, 1'b0, 12, 0);

      // Randomized layers with MAC gaps and ignored mid-layer op_en/cfg
      for (int r = 0; r < 6; r++) begin
         fill(2);
         run_layer(int'($urandom_range(1, 32)), int'($urandom_range(0, 3)), 1'b1, 1'b1, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cacc_psum_sequencer.md
# cacc_psum_sequencer

Upstream sequencer for the int8 CACC calculation stage. Accepts the MAC result stream one element per beat, tracks stripe position and channel-group index, fetches the stored partial sum for that position from a local partial-sum buffer, and drives the calculation stage's data, operand, select and valid inputs. Saturated 34-bit partial sums returned by the calculation stage are written back into the buffer. The next channel group accumulates onto them until the last group, which is issued as a final (rounded/truncated) pass.

## Interface
Parameters:
- DEPTH, 32, partial-sum buffer entries (max stripe length)
- AW, 5, buffer address width, log2(DEPTH)

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  reset. One clock; reset is synchronous and active-low.
- cfg_stripe_len  in  AW+1  atoms per stripe, legal 1..DEPTH; sampled on op_en
- cfg_group_num  in  8  channel groups minus 1; sampled on op_en
- op_en  in  1  layer start pulse; honoured only in IDLE
- mac_pvld  in  1  MAC element valid
- mac_prdy  out  1  MAC element accepted when high with mac_pvld
- mac_data  in  22  signed MAC sum
- calc_in_data  out  22  to calc stage in_data
- calc_in_op  out  34  to calc stage in_op (stored partial sum)
- calc_in_op_valid  out  1  to calc stage in_op_valid
- calc_in_sel  out  1  to calc stage in_sel (1 = final pass)
- calc_in_valid  out  1  to calc stage in_valid
- calc_partial_data  in  34  from calc stage out_partial_data
- calc_partial_valid  in  1  from calc stage out_partial_valid
- busy  out  1  high outside IDLE
- layer_done  out  1  one-cycle pulse at end of layer
- err_wb  out  1  sticky: write-back arrived for a non-pending entry

## Operation
- FSM states:
  - IDLE: on op_en, latch cfg, clear counters, go to RUN.
  - RUN: issue elements. After the last atom of the last group is accepted, go to DRAIN.
  - DRAIN: wait 2 cycles (calc pipeline depth), pulse layer_done, go to IDLE.
- Counters:
  - atom_cnt runs 0..stripe_len-1 and is the read address.
  - group_cnt runs 0..group_num and advances when atom_cnt wraps.
- Issue: calc_in_valid = mac_pvld & mac_prdy; calc_in_data = mac_data.
  - calc_in_op_valid = (group_cnt != 0).
  - calc_in_sel = (group_cnt == group_num). When group_num = 0, the single group has op_valid=0 and sel=1.
- Operand: calc_in_op = buffer[atom_cnt], forwarded from calc_partial_data if a write-back to the same address lands in the same cycle. calc_in_op is zero when op_valid=0.
- Pending bits, one per entry:
  - Set on each non-final issue.
  - Cleared on write-back.
  - A same-cycle set and clear on one entry leaves it set.
- Hazard stall: mac_prdy = RUN & !(pending[atom_cnt] & !(calc_partial_valid & wb_addr == atom_cnt)).
  - stripe_len ≥ 3 never stalls; stripe_len = 2 uses forwarding; stripe_len = 1 stalls 1 cycle per group.
- Write-back: on calc_partial_valid, write buffer[wb_addr], then wb_addr advances, wrapping at stripe_len-1.
  - If pending[wb_addr] = 0, set err_wb; the write still occurs.
- Widths: the buffer stores 34-bit two's complement, written as received. No arithmetic in this block.
- op_en outside IDLE is ignored. cfg changes outside IDLE are ignored.

## Timing
- Reset values:
  - mac_prdy=0, calc_in_valid=0, calc_in_op_valid=0, calc_in_sel=0, calc_in_data=0, calc_in_op=0.
  - busy=0, layer_done=0, err_wb=0.
  - Reset also clears FSM (IDLE), counters, wb_addr and the pending bits. Buffer contents are not reset.
- Issue path is combinational: MAC beat to calc inputs in the same cycle, 0 latency.
- Calc stage returns the partial sum 2 cycles after issue. The buffer write is visible to reads in the next cycle; the forwarding path covers the same cycle.
- mac_prdy is first high the cycle after op_en. Timing for stripe_len S, G = group_num+1, no MAC gaps:
  - Last accept at cycle op_en + S·G (+ stalls).
  - layer_done pulses 3 cycles after the last accept.
- Reset asserted mid-layer aborts at the next edge: outputs go to reset values and in-flight write-backs are dropped.
- mac_pvld gaps freeze the counters and leave pending unaffected.

## Structure
- Shared package (cacc_pkg): FSM state enum {IDLE, RUN, DRAIN}, constants CALC_LAT=2, PSUM_W=34, MAC_W=22.
- Sub-module cacc_psum_buf: DEPTH×34 register file with one combinational read port, one write port and the same-address forwarding mux.
- Counters, pending bits and FSM stay in the top level.

## Test plan
- stripe_len=4, group_num=2, MAC values 1,2,3,4 repeated, calc model attached:
  - Group 0 has op_valid=0, sel=0.
  - Group 1 has calc_in_op = 1,2,3,4.
  - Group 2 has sel=1 and op = 2,4,6,8.
  - layer_done pulses 3 cycles after the 12th accept.
- stripe_len=1, group_num=3, continuous mac_pvld: mac_prdy low exactly 1 cycle between groups; the op sequence is 0 (op_valid=0), then 5, 10, 15 for mac_data=5.
- stripe_len=2, group_num=1: no stall. The group-1 operands come from forwarding (same-cycle write-back), values match the group-0 sums.
- group_num=0, stripe_len=3: every issue has sel=1 and op_valid=0, no write-backs, err_wb stays 0.
- Inject calc_partial_valid while IDLE: err_wb rises the next cycle and stays high until reset.
- Assert reset after 5 accepts of a 4×3 layer: at the next edge busy=0, mac_prdy=0, pending cleared. A new op_en starts group 0 cleanly with op_valid=0.
